// File: rtl/rv32i_types.sv
// Shared types for the memory-side blocks: arbiter FSM encoding and default widths.
package rv32i_types;

    localparam int DEF_NUM_PORTS = 2;
    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_LINE_W    = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first requester strictly after ptr_i, wrapping.
module rr_picker #(
    parameter  int NUM_PORTS = 2,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic                 valid_o,
    output logic [IDX_W-1:0]     idx_o
);

    logic [IDX_W-1:0] pos;

    // Walk offsets from farthest to nearest so the nearest requester wins last.
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        pos     = '0;
        for (int off = NUM_PORTS; off >= 1; off--) begin
            pos = IDX_W'((int'(ptr_i) + off) % NUM_PORTS);
            if (req_i[pos]) idx_o = pos;
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter funnelling NUM_PORTS cache ports onto one L2 port,
// one transaction at a time (IDLE -> BUSY -> DONE).
module mem_arbiter_rr
    import rv32i_types::*;
#(
    parameter  int NUM_PORTS = DEF_NUM_PORTS,
    parameter  int ADDR_W    = DEF_ADDR_W,
    parameter  int LINE_W    = DEF_LINE_W,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0] req_address,
    input  logic [NUM_PORTS-1:0][LINE_W-1:0] req_wdata,
    input  logic [NUM_PORTS-1:0]             req_read,
    input  logic [NUM_PORTS-1:0]             req_write,
    output logic [NUM_PORTS-1:0][LINE_W-1:0] req_rdata,
    output logic [NUM_PORTS-1:0]             req_resp,
    output logic [ADDR_W-1:0]                l2_address,
    output logic [LINE_W-1:0]                l2_wdata,
    output logic                             l2_read,
    output logic                             l2_write,
    input  logic [LINE_W-1:0]                l2_rdata,
    input  logic                             l2_resp,
    output logic                             busy,
    output logic [IDX_W-1:0]                 grant_idx
);

    arb_state_e                        state_q, state_d;
    logic [IDX_W-1:0]                  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]                  win_q, win_d;
    logic [ADDR_W-1:0]                 addr_q, addr_d;
    logic [LINE_W-1:0]                 wdata_q, wdata_d;
    logic                              wr_q, wr_d;
    logic [NUM_PORTS-1:0][LINE_W-1:0]  rdata_q;
    logic [NUM_PORTS-1:0]              req_any;
    logic                              pick_vld;
    logic [IDX_W-1:0]                  pick_idx;
    logic                              cap_en;

    assign req_any = req_read | req_write;

    rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
        .req_i   (req_any),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_vld),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        cap_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Read+write together is a write: req_write alone selects the op.
                if (pick_vld) begin
                    win_d   = pick_idx;
                    addr_d  = req_address[pick_idx];
                    wdata_d = req_wdata[pick_idx];
                    wr_d    = req_write[pick_idx];
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (l2_resp) begin
                    cap_en  = !wr_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                rr_ptr_d = win_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= IDX_W'(NUM_PORTS - 1);
            win_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
        end
    end

    // Per-port read line is sticky until that port's next completed read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rdata_q <= '0;
        else if (cap_en) rdata_q[win_q] <= l2_rdata;
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_resp
        assign req_resp[i] = (state_q == DONE) && (win_q == IDX_W'(i));
    end

    assign req_rdata  = rdata_q;
    assign l2_address = addr_q;
    assign l2_wdata   = wdata_q;
    assign l2_read    = (state_q == BUSY) && !wr_q;
    assign l2_write   = (state_q == BUSY) &&  wr_q;
    assign busy       = (state_q != IDLE);
    assign grant_idx  = win_q;

endmodule
